// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_slave_ctrl                                             |
// | Description : SPI slave front-end. Assembles 10-bit command/payload      |
// |               frames from MOSI and serialises RAM read data on MISO.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spi_slave_ctrl #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic               clk_SPI,
    input  logic               rst_n_SPI,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam int TXC_W = $clog2(DATA_W + 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_CHK_CMD   = 3'd1;
    localparam logic [2:0] c_WRITE     = 3'd2;
    localparam logic [2:0] c_READ_ADD  = 3'd3;
    localparam logic [2:0] c_READ_DATA = 3'd4;

    localparam logic [CNT_W-1:0] c_FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] c_FRAME_FULL = CNT_W'(FRAME_W);
    localparam logic [TXC_W-1:0] c_TX_FULL    = TXC_W'(DATA_W);

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [FRAME_W-1:0] r_shift;
    logic               r_rd_seen;
    logic [DATA_W-1:0]  r_tx_sr;
    logic [TXC_W-1:0]   r_tx_cnt;
    logic               r_tx_act;
    logic               r_tx_done;

    logic w_rx_state;
    logic w_sample;
    logic w_last;
    logic w_wait;

    // Receive phase is active until the frame counter reaches FRAME_W; the
    // read-data wait phase follows only once the whole frame is in.
    assign w_rx_state = (r_state == c_WRITE) || (r_state == c_READ_ADD) ||
                        (r_state == c_READ_DATA);
    assign w_sample   = !SS_n && w_rx_state && (r_cnt < c_FRAME_FULL);
    assign w_last     = w_sample && (r_cnt == c_FRAME_LAST);
    assign w_wait     = !SS_n && (r_state == c_READ_DATA) &&
                        (r_cnt == c_FRAME_FULL) && !r_tx_act && !r_tx_done;

    // Frame FSM: command decode, MOSI shift-in and the one-cycle rx strobe.
    always_ff @(posedge clk_SPI or negedge rst_n_SPI) begin
        if (!rst_n_SPI) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                // Deselect discards any partial frame.
                r_state <= c_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_state <= c_CHK_CMD;
                    end
                    c_CHK_CMD: begin
                        r_shift <= {{(FRAME_W-1){1'b0}}, MOSI};
                        r_cnt   <= CNT_W'(1);
                        if (!MOSI) begin
                            r_state <= c_WRITE;
                        end else if (r_rd_seen) begin
                            r_state <= c_READ_DATA;
                        end else begin
                            r_state <= c_READ_ADD;
                        end
                    end
                    c_WRITE, c_READ_ADD, c_READ_DATA: begin
                        if (w_sample) begin
                            r_shift <= {r_shift[FRAME_W-2:0], MOSI};
                            r_cnt   <= r_cnt + 1'b1;
                            if (w_last) begin
                                rx_data  <= {r_shift[FRAME_W-2:0], MOSI};
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    // Read path: track the address-seen flag, latch tx_data once, and shift
    // it out MSB first; the MSB appears in the cycle right after the latch.
    always_ff @(posedge clk_SPI or negedge rst_n_SPI) begin
        if (!rst_n_SPI) begin
            MISO      <= 1'b0;
            r_rd_seen <= 1'b0;
            r_tx_sr   <= '0;
            r_tx_cnt  <= '0;
            r_tx_act  <= 1'b0;
            r_tx_done <= 1'b0;
        end else if (SS_n) begin
            // An aborted transmit keeps r_rd_seen so the read can be retried.
            MISO      <= 1'b0;
            r_tx_cnt  <= '0;
            r_tx_act  <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            if (w_last && (r_state == c_READ_ADD)) begin
                r_rd_seen <= 1'b1;
            end
            if (w_wait && tx_valid) begin
                MISO     <= tx_data[DATA_W-1];
                r_tx_sr  <= {tx_data[DATA_W-2:0], 1'b0};
                r_tx_cnt <= TXC_W'(1);
                r_tx_act <= 1'b1;
            end else if (r_tx_act) begin
                if (r_tx_cnt == c_TX_FULL) begin
                    MISO      <= 1'b0;
                    r_tx_act  <= 1'b0;
                    r_tx_done <= 1'b1;
                    r_rd_seen <= 1'b0;
                end else begin
                    MISO     <= r_tx_sr[DATA_W-1];
                    r_tx_sr  <= {r_tx_sr[DATA_W-2:0], 1'b0};
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spi_slave_ctrl                                          |
// | Description : Self-checking bench for spi_slave_ctrl: directed vector    |
// |               table, hand-written corner sequences, random transactions.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_spi_slave_ctrl;

    logic       clk_SPI = 1'b0;
    logic       rst_n_SPI;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: has a read-address frame been seen, and the
    // last completed frame (rx_data must hold it).
    logic       m_rd_seen;
    logic [9:0] m_last_rx;

    // kind: 0 = frame aborted, 1 = frame with no read-out, 2 = read-data frame
    typedef struct {
        logic [9:0] frame;
        int         nbits;
        int         dly;
        logic [7:0] txd;
        int         abort_at;   // 0: deselect before tx_valid, 1..7: after that many bits, 9: full
        int         exp_kind;
        logic [9:0] exp_rx;
    } vec_t;

    vec_t vecs[14];

    spi_slave_ctrl #(.FRAME_W(10), .DATA_W(8)) u_dut (
        .clk_SPI  (clk_SPI),
        .rst_n_SPI(rst_n_SPI),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk_SPI = ~clk_SPI;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_SPI);
        #1;
    endtask

    // Routing decided from the protocol rules, not from any RTL encoding.
    function automatic int model_kind(input logic [9:0] f, input int nbits, input logic seen);
        if (nbits < 10) return 0;
        if (f[9] && seen) return 2;
        return 1;
    endfunction

    function automatic logic model_seen_after(input int kind, input logic [9:0] f,
                                              input int abort_at, input logic seen);
        if (kind == 1 && f[9]) return 1'b1;
        if (kind == 2 && abort_at == 9) return 1'b0;
        return seen;
    endfunction

    task automatic run_txn(input logic [9:0] f, input int nbits, input int dly,
                           input logic [7:0] txd, input int abort_at,
                           input int kind, input logic [9:0] exp_rx);
        int nb;
        SS_n = 1'b0; MOSI = 1'($urandom); tx_valid = 1'b0;
        tick();
        for (int i = 0; i < nbits; i++) begin
            MOSI = f[9-i];
            check("rx_valid_during_shift", rx_valid, 0);
            tick();
        end
        if (kind == 0) begin
            SS_n = 1'b1;
            tick();
            check("rx_valid_after_abort", rx_valid, 0);
        end else begin
            check("rx_valid_pulse", rx_valid, 1);
            check("rx_data_frame", rx_data, exp_rx);
            if (kind == 1) begin
                for (int i = 0; i < 3; i++) begin
                    MOSI = 1'($urandom); tx_valid = 1'($urandom); tx_data = 8'($urandom);
                    tick();
                    check("rx_valid_single", rx_valid, 0);
                    check("miso_idle_no_read", MISO, 0);
                end
            end else begin
                MOSI = 1'($urandom);
                for (int i = 0; i < dly; i++) begin
                    tick();
                    check("miso_wait", MISO, 0);
                    check("rx_valid_single", rx_valid, 0);
                end
                if (abort_at != 0) begin
                    tx_valid = 1'b1; tx_data = txd;
                    tick();
                    nb = (abort_at == 9) ? 8 : abort_at;
                    for (int j = 0; j < nb; j++) begin
                        if (j > 0) tick();
                        check("miso_bit", MISO, txd[7-j]);
                        tx_data = 8'($urandom);
                        MOSI = 1'($urandom);
                    end
                    if (abort_at == 9) begin
                        for (int i = 0; i < 3; i++) begin
                            tick();
                            check("miso_after_tx", MISO, 0);
                        end
                    end
                end
            end
        end
        SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0;
        tick();
        check("miso_deselect", MISO, 0);
        check("rx_valid_deselect", rx_valid, 0);
        check("rx_data_hold", rx_data, exp_rx);
    endtask

    task automatic model_txn(input logic [9:0] f, input int nbits, input int dly,
                             input logic [7:0] txd, input int abort_at);
        int k;
        logic [9:0] e;
        k = model_kind(f, nbits, m_rd_seen);
        e = (k == 0) ? m_last_rx : f;
        run_txn(f, nbits, dly, txd, abort_at, k, e);
        m_rd_seen = model_seen_after(k, f, abort_at, m_rd_seen);
        m_last_rx = e;
    endtask

    initial begin
        vecs[0]  = '{10'h0A5, 10, 0, 8'h00, 9, 1, 10'h0A5};
        vecs[1]  = '{10'h1F0, 10, 0, 8'h00, 9, 1, 10'h1F0};
        vecs[2]  = '{10'h23C, 10, 0, 8'h00, 9, 1, 10'h23C};
        vecs[3]  = '{10'h355, 10, 2, 8'hC3, 9, 2, 10'h355};
        vecs[4]  = '{10'h3AA, 10, 0, 8'h00, 9, 1, 10'h3AA};
        vecs[5]  = '{10'h0F5,  5, 0, 8'h00, 9, 0, 10'h3AA};
        vecs[6]  = '{10'h001, 10, 0, 8'h00, 9, 1, 10'h001};
        vecs[7]  = '{10'h3E1, 10, 1, 8'h5A, 3, 2, 10'h3E1};
        vecs[8]  = '{10'h2FF, 10, 3, 8'hA5, 9, 2, 10'h2FF};
        vecs[9]  = '{10'h3FF, 10, 0, 8'h00, 9, 1, 10'h3FF};
        vecs[10] = '{10'h2B0,  7, 0, 8'h00, 9, 0, 10'h3FF};
        vecs[11] = '{10'h300, 10, 4, 8'h81, 0, 2, 10'h300};
        vecs[12] = '{10'h3C3, 10, 1, 8'h3C, 9, 2, 10'h3C3};
        vecs[13] = '{10'h200, 10, 0, 8'h00, 9, 1, 10'h200};

        rst_n_SPI = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        m_rd_seen = 1'b0; m_last_rx = 10'h000;
        #12;
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_miso", MISO, 0);
        rst_n_SPI = 1'b1;
        tick();
        tick();

        // Directed vectors with hand-computed expectations.
        for (int v = 0; v < 14; v++) begin
            run_txn(vecs[v].frame, vecs[v].nbits, vecs[v].dly, vecs[v].txd,
                    vecs[v].abort_at, vecs[v].exp_kind, vecs[v].exp_rx);
        end
        m_rd_seen = 1'b1; m_last_rx = 10'h200;

        // Deselect in the same cycle the strobe is high: strobe still lasts one cycle.
        SS_n = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin
            MOSI = (i % 2 == 1); tick();
        end
        check("strobe_with_deselect", rx_valid, 1);
        check("strobe_with_deselect_data", rx_data, 10'h155);
        SS_n = 1'b1;
        tick();
        check("strobe_cleared", rx_valid, 0);
        check("strobe_miso", MISO, 0);
        m_last_rx = 10'h155;
        tick();

        // Async reset in the middle of shifting out 8'hC3 (rd_seen is 1 here).
        SS_n = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin
            MOSI = 1'b1; tick();
        end
        check("pre_reset_rx_valid", rx_valid, 1);
        check("pre_reset_rx_data", rx_data, 10'h3FF);
        tick();
        tx_valid = 1'b1; tx_data = 8'hC3;
        tick();
        check("pre_reset_bit7", MISO, 1);
        tick();
        check("pre_reset_bit6", MISO, 1);
        tick();
        check("pre_reset_bit5", MISO, 0);
        tick();
        check("pre_reset_bit4", MISO, 0);
        #2;
        rst_n_SPI = 1'b0;
        #1;
        check("async_reset_miso", MISO, 0);
        check("async_reset_rx_valid", rx_valid, 0);
        check("async_reset_rx_data", rx_data, 0);
        SS_n = 1'b1; tx_valid = 1'b0;
        #1;
        rst_n_SPI = 1'b1;
        tick();
        check("post_reset_miso", MISO, 0);
        m_rd_seen = 1'b0; m_last_rx = 10'h000;
        // Read-data command now routes to the address path, then a real read.
        model_txn(10'h3C3, 10, 2, 8'hC3, 9);
        model_txn(10'h3C3, 10, 2, 8'hC3, 9);

        // Randomized transactions against the model.
        for (int t = 0; t < 60; t++) begin
            logic [9:0] f;
            int nbits, dly, ab;
            f     = 10'($urandom);
            nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 9)) : 10;
            dly   = int'($urandom_range(1, 4));
            ab    = int'($urandom_range(0, 10));
            if (ab > 7) ab = 9;
            model_txn(f, nbits, dly, 8'($urandom), ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
SPI slave front-end of the SPI RAM. It sits directly upstream of the RAM command/data path and drives the frame-assembly shift register stage. It tracks SS_n and counts MOSI bits into 10-bit frames: a 2-bit command followed by 8 address or data bits. Completed frames go to the RAM as rx_data/rx_valid. For reads, it serialises the RAM's tx_data back out on MISO.

Parameters:
FRAME_W, 10, received frame width: command bits [FRAME_W-1:FRAME_W-2] plus payload.
DATA_W, 8, read-data width shifted out on MISO.

Ports:
clk_SPI  input  1  SPI clock; all state updates on posedge.
rst_n_SPI  input  1  reset, asynchronous, active-low.
SS_n  input  1  slave select, active-low, frames a transaction.
MOSI  input  1  serial data in, MSB first, sampled on posedge.
MISO  output  1  serial read data out, MSB first.
rx_data  output  FRAME_W  assembled frame {cmd[1:0], payload[7:0]}.
rx_valid  output  1  one-cycle strobe, rx_data valid.
tx_data  input  DATA_W  read data from RAM.
tx_valid  input  1  tx_data valid, level; sampled only in READ_DATA wait phase.

Behaviour:
- Reset (async, rst_n_SPI=0):
  - state=IDLE; rx_data=0; rx_valid=0; MISO=0.
  - bit counter=0; rd_addr_seen=0; tx shift register=0.
  - Takes effect immediately, including mid-frame.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- SS_n=1 at any posedge, any state: next state IDLE.
  - Counter cleared; no rx_valid; MISO=0.
  - rd_addr_seen unchanged.
  - A partial frame is discarded.
- IDLE: SS_n=0 -> CHK_CMD. MOSI ignored.
- CHK_CMD:
  - Samples MOSI as frame bit FRAME_W-1; counter=1.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Shift MOSI in, MSB first, one bit per posedge, until counter=FRAME_W.
  - The cycle after the FRAME_W-th sample: rx_data=assembled frame, rx_valid=1 for exactly one cycle.
  - rx_data holds until the next completed frame.
- After frame completion in WRITE/READ_ADD: MOSI ignored until SS_n=1.
- READ_ADD completion: rd_addr_seen=1 in the same cycle as rx_valid.
- READ_DATA after its rx_valid: wait for tx_valid=1. No timeout; SS_n=1 aborts.
  - First posedge with tx_valid=1: latch tx_data.
  - From the next cycle, MISO drives bit DATA_W-1, then successive bits, one per posedge, for DATA_W cycles total.
  - Then MISO=0, rd_addr_seen=0, and the block ignores MOSI/tx_valid until SS_n=1.
- SS_n=1 mid-transmit: MISO=0, rd_addr_seen stays 1, so the next read-command frame re-enters READ_DATA.
- tx_valid outside the READ_DATA wait phase: ignored.
- rx_valid and SS_n rising at the same posedge: the strobe still completes its single cycle.
- Frame latency: rx_valid asserted 1 cycle after the last MOSI bit; SS_n falling to first sample is 1 cycle (IDLE->CHK_CMD).

Test Plan:
1. Write-address frame: SS_n=0, MOSI=00_1010_0101 -> single rx_valid pulse, rx_data=10'h0A5. SS_n=1 -> IDLE, MISO stays 0.
2. Write-data frame 01_1111_0000 -> rx_data=10'h1F0, one rx_valid pulse. rd_addr_seen stays 0.
3. Read-address frame 10_0011_1100, then new frame 11_xxxxxxxx with tx_valid=1 and tx_data=8'hC3 two cycles after rx_valid:
   - First frame: rx_data=10'h23C.
   - Second frame enters READ_DATA.
   - MISO=1,1,0,0,0,0,1,1 on consecutive cycles, then 0; rd_addr_seen cleared.
4. Read-data command with rd_addr_seen=0 (MOSI first bit 1 right after reset) -> FSM goes to READ_ADD; completes as address frame; no MISO activity.
5. SS_n=1 after 5 bits of a write frame -> no rx_valid. Following full frame 00_0000_0001 -> rx_data=10'h001 correct.
6. rst_n_SPI=0 mid-MISO transmission (bit 3 of 8'hC3) -> MISO=0, rx_valid=0, state IDLE immediately without clock edge. Post-reset read-data frame routes to READ_ADD.
